// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: pointer-width rule, Gray/binary conversion
// and the read-side output state type.
package fifo_pkg;

  localparam int unsigned MaxPtrWidth = 32;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } rd_state_e;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  // Callers zero-extend to MaxPtrWidth and truncate the result; the zero upper bits
  // leave the conversion exact for any narrower pointer width.
  function automatic logic [MaxPtrWidth-1:0] bin2gray(input logic [MaxPtrWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MaxPtrWidth-1:0] gray2bin(input logic [MaxPtrWidth-1:0] gray);
    logic [MaxPtrWidth-1:0] bin;
    bin[MaxPtrWidth-1] = gray[MaxPtrWidth-1];
    for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the clk domain.
module ptr_sync #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: syncs the write pointer, owns the read pointer
// and presents RAM data as a first-word-fall-through registered valid/ready stream.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_empty,
  output logic [ADDR_WIDTH:0]   rd_level
);

  localparam int unsigned PtrWidth = ptr_width(ADDR_WIDTH);

  rd_state_e             state_q, state_d;
  logic [PtrWidth-1:0]   rd_ptr_bin_q, rd_ptr_bin_d;
  logic [PtrWidth-1:0]   rd_ptr_gray_q, rd_ptr_gray_d;
  logic [PtrWidth-1:0]   rd_ptr_bin_inc;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [PtrWidth-1:0]   wr_gray_s;
  logic [PtrWidth-1:0]   wr_bin_s;
  logic                  ram_empty;
  logic                  fetch;

  // Only the Gray value crosses; binary is rebuilt locally after the synchroniser.
  ptr_sync #(
    .WIDTH      (PtrWidth),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clk(rd_clk),
    .rst(rd_rst),
    .d  (wr_ptr_gray),
    .q  (wr_gray_s)
  );

  assign wr_bin_s       = PtrWidth'(gray2bin(MaxPtrWidth'(wr_gray_s)));
  assign rd_ptr_bin_inc = rd_ptr_bin_q + 1'b1;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q       <= StIdle;
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      rd_data_q     <= rd_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_ptr_bin_d  = rd_ptr_bin_q;
    rd_ptr_gray_d = rd_ptr_gray_q;
    rd_data_d     = rd_data_q;
    unique case (state_q)
      StIdle:  if (fetch) state_d = StIdle == StIdle ? StHold : StIdle;
      StHold:  if (rd_ready && !fetch) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (fetch) begin
      rd_data_d     = ram_rd_data;
      rd_ptr_bin_d  = rd_ptr_bin_inc;
      rd_ptr_gray_d = PtrWidth'(bin2gray(MaxPtrWidth'(rd_ptr_bin_inc)));
    end
  end

  always_comb begin
    rd_valid    = (state_q == StHold);
    rd_data     = rd_data_q;
    rd_ptr_gray = rd_ptr_gray_q;
    rd_addr     = rd_ptr_bin_q[ADDR_WIDTH-1:0];
    ram_empty   = (wr_gray_s == rd_ptr_gray_q);
    // Refill the output register when it is empty or being consumed this cycle.
    fetch       = !ram_empty && (!rd_valid || rd_ready);
    rd_empty    = ram_empty && !rd_valid;
    rd_level    = (wr_bin_s - rd_ptr_bin_q) + PtrWidth'(rd_valid);
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural RAM and write-side driver feed a scoreboard queue
// that a negedge monitor drains as words are accepted.
module tb_fifo_rd_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned PW    = 5;

  logic          clk = 1'b0;
  logic          rd_rst;
  logic [PW-1:0] wr_ptr_gray;
  logic [PW-1:0] rd_ptr_gray;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_empty;
  logic [PW-1:0] rd_level;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [PW-1:0] wr_bin;

  int n_total = 0;
  int n_bad = 0;
  int n_written = 0;
  int n_consumed = 0;
  int addr_wraps = 0;
  int gray_zeros = 0;

  always #5 clk = ~clk;

  assign ram_rd_data = mem[rd_addr];

  fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(2)
  ) dut (
    .rd_clk     (clk),
    .rd_rst     (rd_rst),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray),
    .rd_addr    (rd_addr),
    .ram_rd_data(ram_rd_data),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_empty   (rd_empty),
    .rd_level   (rd_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wr_bin[AW-1:0]] = d;
    wr_bin      = wr_bin + 1'b1;
    wr_ptr_gray = wr_bin ^ (wr_bin >> 1);
    exp_q.push_back(d);
    n_written++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rd_rst      = 1'b1;
    rd_ready    = 1'b0;
    wr_bin      = '0;
    wr_ptr_gray = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rd_rst = 1'b0;
  endtask

  // Monitor: rd_rst/rd_ready seen at a negedge are what the next posedge samples.
  logic          prev_rst = 1'b1;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic [PW-1:0] prev_gray;
  logic [AW-1:0] prev_addr;

  always @(negedge clk) begin
    if (!prev_rst) begin
      if (prev_hold) begin
        check("hold_valid", 32'(rd_valid), 32'd1);
        check("hold_data", 32'(rd_data), 32'(prev_data));
      end
      if (rd_ptr_gray != prev_gray) begin
        check("gray_step", $countones(rd_ptr_gray ^ prev_gray), 32'd1);
        if (rd_ptr_gray == '0) gray_zeros++;
      end
      if (prev_addr == 4'd15 && rd_addr == 4'd0) addr_wraps++;
    end
    if (!rd_rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_word: got %0h want none", rd_data);
      end else begin
        check("data_order", 32'(rd_data), 32'(exp_q.pop_front()));
        n_consumed++;
      end
    end
    prev_hold = !rd_rst && rd_valid && !rd_ready;
    prev_data = rd_data;
    prev_gray = rd_ptr_gray;
    prev_addr = rd_addr;
    prev_rst  = rd_rst;
  end

  initial begin
    int cnt;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rd_rst      = 1'b1;
    rd_ready    = 1'b0;
    wr_ptr_gray = '0;
    wr_bin      = '0;

    // Reset
    repeat (3) @(posedge clk);
    #1 rd_rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_empty", 32'(rd_empty), 32'd1);
    check("rst_level", 32'(rd_level), 32'd0);
    check("rst_gray", 32'(rd_ptr_gray), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);

    // Single word: pointer changes after edge 0, word appears at edge 3
    @(posedge clk);
    #1 write_word(8'hA5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("single_early_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("single_valid", 32'(rd_valid), 32'd1);
    check("single_data", 32'(rd_data), 32'hA5);
    check("single_addr", 32'(rd_addr), 32'd1);
    check("single_gray", 32'(rd_ptr_gray), 32'd1);
    check("single_level", 32'(rd_level), 32'd1);
    check("single_empty", 32'(rd_empty), 32'd0);
    @(posedge clk);
    #1 rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_ready = 1'b0;
    @(negedge clk);
    check("single_drained_valid", 32'(rd_valid), 32'd0);
    check("single_drained_empty", 32'(rd_empty), 32'd1);

    // Streaming: prefill 16 words, then drain back-to-back
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 write_word(DW'(i));
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stream_level_full", 32'(rd_level), 32'd16);
    check("stream_first", 32'(rd_data), 32'h00);
    @(posedge clk);
    #1 rd_ready = 1'b1;
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (!rd_valid) cnt++;
    end
    check("stream_bubbles", 32'(cnt), 32'd0);
    @(negedge clk);
    check("stream_end_valid", 32'(rd_valid), 32'd0);
    check("stream_end_empty", 32'(rd_empty), 32'd1);
    check("stream_end_level", 32'(rd_level), 32'd0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 write_word(DW'(8'h31 + i));
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_valid", 32'(rd_valid), 32'd1);
    check("bp_data", 32'(rd_data), 32'h31);
    check("bp_level", 32'(rd_level), 32'd3);
    check("bp_gray", 32'(rd_ptr_gray), 32'd1);
    repeat (3) @(posedge clk);
    #1 rd_ready = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rd_valid) cnt++;
    end
    check("bp_drain_cycles", 32'(cnt), 32'd3);
    @(negedge clk);
    check("bp_drain_valid", 32'(rd_valid), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Wrap: 40 words with random backpressure
    do_reset();
    n_written  = 0;
    n_consumed = 0;
    addr_wraps = 0;
    gray_zeros = 0;
    fork
      begin : wr_proc
        for (int c = 0; c < 4000 && n_written < 40; c++) begin
          @(posedge clk);
          #1;
          if (n_written - n_consumed < 16) write_word(DW'(8'h40 + n_written));
        end
      end
      begin : rd_proc
        int cyc;
        cyc = 0;
        while (n_consumed < 40 && cyc < 4000) begin
          @(posedge clk);
          #1 rd_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        if (n_consumed < 40) begin
          n_total++;
          n_bad++;
          $display("FAIL wrap_timeout: consumed %0d want 40", n_consumed);
        end
      end
    join
    rd_ready = 1'b0;
    @(negedge clk);
    check("wrap_addr_wraps", 32'(addr_wraps), 32'd2);
    check("wrap_gray_zero", 32'(gray_zeros), 32'd1);
    check("wrap_final_gray", 32'(rd_ptr_gray), 32'd12);
    check("wrap_final_addr", 32'(rd_addr), 32'd8);
    check("wrap_final_empty", 32'(rd_empty), 32'd1);

    // Mid-stream reset discards held and unfetched words
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 write_word(DW'(8'h90 + i));
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_level", 32'(rd_level), 32'd5);
    check("mid_valid", 32'(rd_valid), 32'd1);
    @(posedge clk);
    #1;
    rd_rst      = 1'b1;
    wr_bin      = '0;
    wr_ptr_gray = '0;
    exp_q.delete();
    @(posedge clk);
    #1 rd_rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_empty", 32'(rd_empty), 32'd1);
    check("mid_rst_level", 32'(rd_level), 32'd0);
    check("mid_rst_gray", 32'(rd_ptr_gray), 32'd0);
    check("mid_rst_addr", 32'(rd_addr), 32'd0);
    check("mid_rst_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1 rd_ready = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_valid) cnt++;
    end
    check("mid_no_delivery", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller of the async FIFO, in the read clock domain.
- Synchronises the write pointer into the read domain, owns the read pointer, and drives the read address of the dual-port RAM.
- Presents RAM data to the consumer as a first-word-fall-through valid/ready stream held in an output register.
- Exports its Gray-coded read pointer to the write side for full detection.

Parameters:
- DATA_WIDTH, 8, word width; must match the RAM.
- DEPTH, 16, RAM depth; must be a power of two, minimum 2.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width.
- SYNC_STAGES, 2, flop stages on the incoming write pointer; minimum 2.

Ports:
- rd_clk  in  1  read clock; the block's only clock.
- rd_rst  in  1  reset, synchronous to rd_clk, active-high.
- wr_ptr_gray  in  ADDR_WIDTH+1  write pointer, Gray-coded, from the write domain; asynchronous to rd_clk.
- rd_ptr_gray  out  ADDR_WIDTH+1  read pointer, Gray-coded, registered; goes to the write-side synchroniser.
- rd_addr  out  ADDR_WIDTH  RAM read address, equal to the low bits of the binary read pointer.
- ram_rd_data  in  DATA_WIDTH  combinational RAM read data for rd_addr.
- rd_data  out  DATA_WIDTH  output word, registered.
- rd_valid  out  1  rd_data holds an unconsumed word.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_empty  out  1  no word in RAM and none in the output register.
- rd_level  out  ADDR_WIDTH+1  words available: unfetched words in RAM plus rd_valid.

Behaviour:
- Reset (rd_rst=1 at a rising rd_clk edge) gives:
  - all sync flops = 0; rd_ptr_bin = 0; rd_ptr_gray = 0; rd_addr = 0;
  - rd_data = 0; rd_valid = 0; rd_empty = 1; rd_level = 0.
- Reset mid-operation discards the held word and any unfetched data. The system resets the write side in the same window.
- Synchroniser:
  - wr_ptr_gray passes through SYNC_STAGES flops, giving wr_gray_s.
  - wr_bin_s = gray2bin(wr_gray_s), computed combinationally.
  - The synchroniser samples only the Gray value; no binary value crosses domains.
- ram_empty is combinational: wr_gray_s == rd_ptr_gray.
- Fetch condition: fetch = !ram_empty && (!rd_valid || rd_ready).
- On a fetch edge:
  - rd_data <= ram_rd_data (the word at the current rd_addr);
  - rd_valid <= 1;
  - rd_ptr_bin <= rd_ptr_bin + 1;
  - rd_ptr_gray <= bin2gray(rd_ptr_bin + 1).
- Output state machine has two states:
  - IDLE (rd_valid=0): fetch moves to HOLD; otherwise stay in IDLE.
  - HOLD (rd_valid=1):
    - rd_ready with fetch: stay in HOLD with the new word (back-to-back transfer).
    - rd_ready without fetch: go to IDLE, rd_valid <= 0.
    - !rd_ready: stay in HOLD; rd_data and rd_valid are held stable.
- Throughput: one word per rd_clk while data is available and rd_ready=1.
- Latency: a change on wr_ptr_gray sampled at edge 0 produces rd_valid=1 at edge SYNC_STAGES+1, assuming IDLE.
- Pointer arithmetic:
  - Pointers are ADDR_WIDTH+1 bits and increment modulo 2^(ADDR_WIDTH+1).
  - rd_addr wraps from DEPTH-1 to 0; the MSB toggles on each lap.
- Levels:
  - rd_level = (wr_bin_s - rd_ptr_bin) mod 2^(ADDR_WIDTH+1) + rd_valid. Maximum value is DEPTH+1, which fits the port width.
  - rd_empty = ram_empty && !rd_valid. Both outputs are combinational from registers.
- rd_ptr_gray changes at most one bit per edge. No outputs are driven combinationally from wr_ptr_gray.

Decomposition:
- Shared package/include fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterised by width;
  - pointer-width constant rule PTR_WIDTH = ADDR_WIDTH+1.
- The write-side controller uses the same package.
- Sub-module ptr_sync (parameters WIDTH, SYNC_STAGES; ports clk, rst, d, q) is reused by the write side for rd_ptr_gray.

Test Plan:
All scenarios use DEPTH=16, SYNC_STAGES=2, with a behavioural RAM model and a write-side driver.
- Reset: hold rd_rst 3 cycles with wr_ptr_gray=0 -> rd_valid=0, rd_empty=1, rd_level=0, rd_ptr_gray=0, rd_data=0.
- Single word: mem[0]=0xA5, wr_ptr_gray 0->1 at edge 0, rd_ready=0 -> at edge 3: rd_valid=1, rd_data=0xA5, rd_addr=1, rd_ptr_gray=1, rd_level=1, rd_empty=0.
- Streaming: 16 words 0x00..0x0F, rd_ready=1 -> 16 consecutive rd_valid cycles, data in order, no bubbles; then rd_valid=0 and rd_empty=1.
- Backpressure: 3 words written, rd_ready=0 -> rd_valid held, rd_data stable, rd_level=3, rd_ptr_gray=1. Raising rd_ready drains 3 words in 3 cycles.
- Wrap: 40 words with random rd_ready -> data order preserved, rd_addr wraps 15->0 twice, rd_ptr_gray returns to 0 after 32 fetches, every rd_ptr_gray change is a single-bit change.
- Mid-stream reset: rd_rst=1 for one edge while rd_valid=1 and rd_level=5 -> next cycle all outputs at reset values, no word delivered.
